// File: rtl/inst_queue_mw.sv
// Multi-lane instruction queue between fetch and decode. Up to FETCH_W pushes and
// ISSUE_W pops per cycle, with a redirect filter that drops wrong-path fetch slots.
module inst_queue_mw #(
  parameter int DEPTH   = 8,
  parameter int FETCH_W = 2,
  parameter int ISSUE_W = 2,
  parameter int CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic [FETCH_W-1:0]           push_valid,
  input  logic [32*FETCH_W-1:0]        push_inst,
  input  logic [32*FETCH_W-1:0]        push_pc,
  output logic                         push_ready,
  input  logic                         redirect_valid,
  input  logic [31:0]                  redirect_pc,
  input  logic [$clog2(ISSUE_W+1)-1:0] pop_num,
  output logic [ISSUE_W-1:0]           out_valid,
  output logic [32*ISSUE_W-1:0]        out_inst,
  output logic [32*ISSUE_W-1:0]        out_pc,
  output logic [CNT_W-1:0]             count,
  output logic                         stallreq,
  output logic [1:0]                   err_sticky
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic {F_IDLE, F_ARMED} filt_e;

  logic [31:0]      inst_mem [DEPTH];
  logic [31:0]      pc_mem   [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  filt_e            filt_q, filt_d;
  logic [31:0]      tgt_q, tgt_d;
  logic [1:0]       err_q, err_d;

  logic             armed_eff;
  logic [31:0]      tgt_eff;
  logic [FETCH_W-1:0] lane_match;
  logic [FETCH_W-1:0] seen;
  logic [FETCH_W-1:0] accept;
  logic [CNT_W-1:0] acc_cnt [FETCH_W+1];
  logic [PTR_W-1:0] waddr   [FETCH_W];
  logic [CNT_W-1:0] npush, npop, pop_ext;

  // A redirect in the current cycle already governs this cycle's push lanes.
  assign armed_eff = redirect_valid | (filt_q == F_ARMED);
  assign tgt_eff   = redirect_valid ? redirect_pc : tgt_q;

  assign push_ready = (CNT_W'(DEPTH) - count_q) >= CNT_W'(FETCH_W);
  assign stallreq   = ~push_ready & ~redirect_valid;
  assign count      = count_q;
  assign err_sticky = err_q;

  assign acc_cnt[0] = '0;

  generate
    for (genvar gi = 0; gi < FETCH_W; gi++) begin : g_lane
      assign lane_match[gi] = push_valid[gi] && (push_pc[32*gi +: 32] == tgt_eff) &&
                              (tgt_eff[1:0] == 2'b00);
      if (gi == 0) begin : g_first
        assign seen[gi] = lane_match[gi];
      end else begin : g_rest
        assign seen[gi] = seen[gi-1] | lane_match[gi];
      end
      assign accept[gi]    = push_valid[gi] & (~armed_eff | seen[gi]) & push_ready;
      assign acc_cnt[gi+1] = acc_cnt[gi] + CNT_W'(accept[gi]);
      // Accepted lanes are compacted: each lands after all earlier accepted lanes.
      assign waddr[gi]     = tail_q + acc_cnt[gi][PTR_W-1:0];
    end
  endgenerate

  assign npush   = acc_cnt[FETCH_W];
  assign pop_ext = CNT_W'(pop_num);

  always_comb begin
    npop = pop_ext;
    if (npop > count_q) npop = count_q;
    if (npop > CNT_W'(ISSUE_W)) npop = CNT_W'(ISSUE_W);
  end

  always_comb begin
    head_d  = head_q + npop[PTR_W-1:0];
    tail_d  = tail_q + npush[PTR_W-1:0];
    count_d = count_q + npush - npop;
    tgt_d   = tgt_eff;
    filt_d  = (armed_eff && !(push_ready && seen[FETCH_W-1])) ? F_ARMED : F_IDLE;
    err_d   = err_q;
    if (!push_ready && (push_valid != '0)) err_d[0] = 1'b1;
    if (pop_ext > count_q) err_d[1] = 1'b1;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      filt_d  = F_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      filt_q  <= F_IDLE;
      tgt_q   <= '0;
      err_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      filt_q  <= filt_d;
      tgt_q   <= tgt_d;
      err_q   <= err_d;
    end
  end

  // Storage carries data only; occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FETCH_W; i++) begin
      if (accept[i] && !flush) begin
        inst_mem[waddr[i]] <= push_inst[32*i +: 32];
        pc_mem[waddr[i]]   <= push_pc[32*i +: 32];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < ISSUE_W; gi++) begin : g_out
      logic [PTR_W-1:0] rd_ptr;
      assign rd_ptr                = head_q + PTR_W'(gi);
      assign out_valid[gi]         = CNT_W'(gi) < count_q;
      assign out_inst[32*gi +: 32] = out_valid[gi] ? inst_mem[rd_ptr] : 32'h0;
      assign out_pc[32*gi +: 32]   = out_valid[gi] ? pc_mem[rd_ptr] : 32'h0;
    end
  endgenerate

endmodule

// File: tb/tb_inst_queue_mw.sv
// Bench for inst_queue_mw: queue-based reference model compared every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_inst_queue_mw;

  localparam int DEPTH   = 8;
  localparam int FETCH_W = 2;
  localparam int ISSUE_W = 2;
  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam logic [31:0] IOFS = 32'h1000_0000;

  logic                  clk, rst, flush;
  logic [FETCH_W-1:0]    push_valid;
  logic [32*FETCH_W-1:0] push_inst, push_pc;
  logic                  push_ready;
  logic                  redirect_valid;
  logic [31:0]           redirect_pc;
  logic [1:0]            pop_num;
  logic [ISSUE_W-1:0]    out_valid;
  logic [32*ISSUE_W-1:0] out_inst, out_pc;
  logic [CNT_W-1:0]      count;
  logic                  stallreq;
  logic [1:0]            err_sticky;

  int n_checks = 0;
  int n_errors = 0;

  inst_queue_mw #(.DEPTH(DEPTH), .FETCH_W(FETCH_W), .ISSUE_W(ISSUE_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .push_valid(push_valid), .push_inst(push_inst), .push_pc(push_pc),
    .push_ready(push_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .pop_num(pop_num),
    .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc),
    .count(count), .stallreq(stallreq), .err_sticky(err_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO of {pc, inst}, filter flag and target, sticky errors.
  logic [63:0] mq[$];
  bit          m_armed = 1'b0;
  logic [31:0] m_tgt   = 32'h0;
  logic [1:0]  m_err   = 2'b00;

  always @(posedge clk or negedge rst) begin : model
    int          npop;
    bit          ready, arm_e, hit;
    logic [31:0] tgt_e, lpc;
    if (!rst) begin
      mq.delete();
      m_armed = 1'b0;
      m_tgt   = 32'h0;
      m_err   = 2'b00;
    end else begin
      ready = (DEPTH - mq.size()) >= FETCH_W;
      if (!ready && push_valid != 0) m_err[0] = 1'b1;
      if (int'(pop_num) > mq.size()) m_err[1] = 1'b1;
      if (flush) begin
        mq.delete();
        m_armed = 1'b0;
      end else begin
        npop = int'(pop_num);
        if (npop > mq.size()) npop = mq.size();
        if (npop > ISSUE_W) npop = ISSUE_W;
        for (int k = 0; k < npop; k++) void'(mq.pop_front());
        arm_e = m_armed || redirect_valid;
        tgt_e = redirect_valid ? redirect_pc : m_tgt;
        hit   = 1'b0;
        if (ready) begin
          for (int l = 0; l < FETCH_W; l++) begin
            if (push_valid[l]) begin
              lpc = push_pc[32*l +: 32];
              if (arm_e && !hit && lpc == tgt_e && tgt_e[1:0] == 2'b00) hit = 1'b1;
              if (!arm_e || hit) mq.push_back({lpc, push_inst[32*l +: 32]});
            end
          end
        end
        m_armed = arm_e && !hit;
        m_tgt   = tgt_e;
      end
    end
  end

  // Single compare process: every falling edge, all outputs against the model.
  always @(negedge clk) begin : compare
    int   sz;
    logic exp_ready;
    sz        = mq.size();
    exp_ready = (DEPTH - sz) >= FETCH_W;
    chk("count", 64'(count), 64'(sz));
    chk("push_ready", 64'(push_ready), 64'(exp_ready));
    chk("stallreq", 64'(stallreq), 64'(!exp_ready && !redirect_valid));
    chk("err_sticky", 64'(err_sticky), 64'(m_err));
    for (int i = 0; i < ISSUE_W; i++) begin
      chk("out_valid", 64'(out_valid[i]), 64'(i < sz));
      chk("out_pc", 64'(out_pc[32*i +: 32]), (i < sz) ? 64'(mq[i][63:32]) : 64'h0);
      chk("out_inst", 64'(out_inst[32*i +: 32]), (i < sz) ? 64'(mq[i][31:0]) : 64'h0);
    end
  end

  task automatic tick(input logic [1:0] pv, input logic [31:0] pc0, input logic [31:0] pc1,
                      input logic [1:0] pn, input logic rv, input logic [31:0] rpc,
                      input logic fl);
    push_valid     = pv;
    push_pc        = {pc1, pc0};
    push_inst      = {pc1 + IOFS, pc0 + IOFS};
    pop_num        = pn;
    redirect_valid = rv;
    redirect_pc    = rpc;
    flush          = fl;
    @(posedge clk);
    #1;
    push_valid     = '0;
    pop_num        = '0;
    redirect_valid = 1'b0;
    flush          = 1'b0;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; push_valid = '0; push_inst = '0; push_pc = '0;
    redirect_valid = 1'b0; redirect_pc = '0; pop_num = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    chk("reset count", 64'(count), 64'd0);
    chk("reset push_ready", 64'(push_ready), 64'd1);
    chk("reset out_valid", 64'(out_valid), 64'd0);

    // Mid-run asynchronous reset at occupancy 5
    tick(2'b11, 32'h10, 32'h14, 2'd0, 1'b0, 32'h0, 1'b0);
    tick(2'b11, 32'h18, 32'h1C, 2'd0, 1'b0, 32'h0, 1'b0);
    tick(2'b01, 32'h20, 32'h24, 2'd0, 1'b0, 32'h0, 1'b0);
    chk("t1 count before reset", 64'(count), 64'd5);
    #2;
    rst = 1'b0;
    #1;
    chk("t1 count in reset", 64'(count), 64'd0);
    chk("t1 out_valid in reset", 64'(out_valid), 64'd0);
    chk("t1 push_ready in reset", 64'(push_ready), 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Fill to DEPTH
    for (int k = 0; k < 4; k++)
      tick(2'b11, 32'h100 + 32'(8*k), 32'h104 + 32'(8*k), 2'd0, 1'b0, 32'h0, 1'b0);
    chk("t2 count full", 64'(count), 64'd8);
    chk("t2 push_ready full", 64'(push_ready), 64'd0);
    chk("t2 stallreq full", 64'(stallreq), 64'd1);
    redirect_valid = 1'b1;
    #1;
    chk("t2 stallreq masked by redirect", 64'(stallreq), 64'd0);
    redirect_valid = 1'b0;

    // Push while full with a same-cycle pop
    tick(2'b11, 32'h900, 32'h904, 2'd2, 1'b0, 32'h0, 1'b0);
    chk("t3 count", 64'(count), 64'd6);
    chk("t3 err_sticky", 64'(err_sticky), 64'd1);
    chk("t3 head pc", 64'(out_pc[31:0]), 64'h108);

    // Over-pop
    tick(2'b00, 32'h0, 32'h0, 2'd2, 1'b0, 32'h0, 1'b0);
    tick(2'b00, 32'h0, 32'h0, 2'd2, 1'b0, 32'h0, 1'b0);
    tick(2'b00, 32'h0, 32'h0, 2'd1, 1'b0, 32'h0, 1'b0);
    chk("t4 out_valid at 1", 64'(out_valid), 64'd1);
    chk("t4 last pc", 64'(out_pc[31:0]), 64'h11C);
    tick(2'b00, 32'h0, 32'h0, 2'd2, 1'b0, 32'h0, 1'b0);
    chk("t4 count", 64'(count), 64'd0);
    chk("t4 err_sticky", 64'(err_sticky), 64'd3);

    // Redirect filter
    tick(2'b00, 32'h0, 32'h0, 2'd0, 1'b1, 32'h208, 1'b0);
    tick(2'b11, 32'h200, 32'h204, 2'd0, 1'b0, 32'h0, 1'b0);
    chk("t5 wrong path dropped", 64'(count), 64'd0);
    tick(2'b11, 32'h208, 32'h20C, 2'd0, 1'b0, 32'h0, 1'b0);
    chk("t5 count", 64'(count), 64'd2);
    chk("t5 out_pc", 64'(out_pc), 64'h0000_020C_0000_0208);
    chk("t5 out_inst0", 64'(out_inst[31:0]), 64'h1000_0208);
    tick(2'b11, 32'h300, 32'h304, 2'd0, 1'b1, 32'h304, 1'b0);
    chk("t5 redirect-cycle filter", 64'(count), 64'd3);
    tick(2'b00, 32'h0, 32'h0, 2'd2, 1'b0, 32'h0, 1'b0);
    chk("t5 target lane kept", 64'(out_pc[31:0]), 64'h304);
    tick(2'b11, 32'h400, 32'h402, 2'd0, 1'b1, 32'h402, 1'b0);
    tick(2'b11, 32'h402, 32'h404, 2'd0, 1'b0, 32'h0, 1'b0);
    chk("t5 misaligned stays armed", 64'(count), 64'd1);
    tick(2'b11, 32'h500, 32'h504, 2'd1, 1'b1, 32'h500, 1'b1);
    chk("t5 flush overrides", 64'(count), 64'd0);
    tick(2'b11, 32'h500, 32'h504, 2'd0, 1'b0, 32'h0, 1'b0);
    chk("t5 filter idle after flush", 64'(count), 64'd2);
    tick(2'b00, 32'h0, 32'h0, 2'd0, 1'b0, 32'h0, 1'b1);
    tick(2'b00, 32'h0, 32'h0, 2'd0, 1'b1, 32'h600, 1'b0);
    tick(2'b00, 32'h0, 32'h0, 2'd0, 1'b1, 32'h700, 1'b0);
    tick(2'b11, 32'h600, 32'h604, 2'd0, 1'b0, 32'h0, 1'b0);
    chk("t5 old target ignored", 64'(count), 64'd0);
    tick(2'b11, 32'h6FC, 32'h700, 2'd0, 1'b0, 32'h0, 1'b0);
    chk("t5 reload count", 64'(count), 64'd1);
    chk("t5 reload pc", 64'(out_pc[31:0]), 64'h700);

    // Wrap-around streaming
    tick(2'b00, 32'h0, 32'h0, 2'd0, 1'b0, 32'h0, 1'b1);
    for (int k = 1; k <= 20; k++) begin
      tick(2'b11, 32'(8*(k-1)), 32'(8*(k-1) + 4), 2'd2, 1'b0, 32'h0, 1'b0);
      chk("t6 lane0 pc", 64'(out_pc[31:0]), 64'(8*(k-1)));
      chk("t6 lane1 pc", 64'(out_pc[63:32]), 64'(8*(k-1) + 4));
    end
    chk("t6 count", 64'(count), 64'd2);

    @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
